mmcm_drp_reconfig: RTL and testbench

- DRP master that reprograms a clocking MMCM at runtime using read-modify-write sequences.
- Holds NUM_CFG configuration sets of REGS_PER_CFG entries each (DRP address, keep-mask, data) in an internal table loaded by the host.
- On a start pulse it holds the MMCM in reset, rewrites the selected set, releases reset and waits for LOCKED, with a lock timeout.
- Sits between the system control logic and the MMCM DRP/RST/LOCKED pins, in the DCLK domain.

---
 rtl/mmcm_drp_reconfig.sv | 213 +++++++++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig: DRP read-modify-write master that reprograms an MMCM at runtime.
// Define MMCM_DRP_VERIFY_EN to add a read-back check of every written register.
module mmcm_drp_reconfig #(
    parameter int NUM_CFG      = 4,
    parameter int REGS_PER_CFG = 23,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int CFG_W        = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1,
    parameter int TBL_AW       = (NUM_CFG * REGS_PER_CFG > 1) ?
                                 $clog2(NUM_CFG * REGS_PER_CFG) : 1
) (
    input  logic              DCLK,
    input  logic              RST_N,
    input  logic [CFG_W-1:0]  SEL,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    input  logic              TBL_WE,
    input  logic [TBL_AW-1:0] TBL_ADDR,
    input  logic [38:0]       TBL_DATA,
    output logic [6:0]        DADDR,
    output logic [15:0]       DI,
    input  logic [15:0]       DO,
    output logic              DEN,
    output logic              DWE,
    input  logic              DRDY,
    input  logic              LOCKED,
    output logic              MMCM_RST
);

    localparam int TBL_N = NUM_CFG * REGS_PER_CFG;
    localparam int LCW   = $clog2(LOCK_TIMEOUT + 2);

    typedef enum logic [3:0] {
        IDLE,
        ASSERT_RST,
        RD_ISSUE,
        RD_WAIT,
        MODIFY,
        WR_ISSUE,
        WR_WAIT,
        VF_ISSUE,
        VF_WAIT,
        REL_RST,
        WAIT_LOCK,
        FINISH
    } state_t;

    state_t            state;
    logic [38:0]       tbl [TBL_N];
    logic [TBL_AW-1:0] ptr;
    logic [TBL_AW-1:0] last_ptr;
    logic [TBL_AW-1:0] ptr_nxt;
    logic [TBL_AW-1:0] base;
    logic [TBL_AW-1:0] base_last;
    logic [CFG_W-1:0]  sel_c;
    logic              addr_ok;
    logic [15:0]       rd_q;
    logic [15:0]       mask_q;
    logic [15:0]       data_q;
    logic [LCW-1:0]    lock_cnt;
    logic [38:0]       ent_cur;
    logic [38:0]       ent_nxt;

    // Out-of-range set indices fall back to the last set
    if ((1 << CFG_W) > NUM_CFG) begin : g_clamp
        assign sel_c = (SEL >= CFG_W'(NUM_CFG)) ? CFG_W'(NUM_CFG - 1) : SEL;
    end else begin : g_noclamp
        assign sel_c = SEL;
    end

    // Writes beyond the populated table are dropped
    if ((1 << TBL_AW) > TBL_N) begin : g_achk
        assign addr_ok = (TBL_ADDR < TBL_AW'(TBL_N));
    end else begin : g_noachk
        assign addr_ok = 1'b1;
    end

    assign base      = TBL_AW'(sel_c) * TBL_AW'(REGS_PER_CFG);
    assign base_last = base + TBL_AW'(REGS_PER_CFG - 1);
    assign ptr_nxt   = ptr + 1'b1;
    assign ent_cur   = tbl[ptr];
    assign ent_nxt   = tbl[ptr_nxt];

    // Host-loaded configuration table; contents survive reset
    always_ff @(posedge DCLK) begin
        if (TBL_WE && addr_ok) begin
            tbl[TBL_ADDR] <= TBL_DATA;
        end
    end

    // Reconfiguration sequencer; all outputs registered
    always_ff @(posedge DCLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            DEN      <= 1'b0;
            DWE      <= 1'b0;
            DADDR    <= '0;
            DI       <= '0;
            MMCM_RST <= 1'b0;
            ptr      <= '0;
            last_ptr <= '0;
            rd_q     <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            lock_cnt <= '0;
        end else begin
            DEN  <= 1'b0;
            DWE  <= 1'b0;
            DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        ptr      <= base;
                        last_ptr <= base_last;
                        ERR      <= 1'b0;
                        BUSY     <= 1'b1;
                        MMCM_RST <= 1'b1;
                        state    <= ASSERT_RST;
                    end
                end
                ASSERT_RST: begin
                    DADDR  <= ent_cur[38:32];
                    mask_q <= ent_cur[31:16];
                    data_q <= ent_cur[15:0];
                    DEN    <= 1'b1;
                    state  <= RD_ISSUE;
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    if (DRDY) begin
                        rd_q  <= DO;
                        state <= MODIFY;
                    end
                end
                MODIFY: begin
                    DI    <= (rd_q & mask_q) | (data_q & ~mask_q);
                    DEN   <= 1'b1;
                    DWE   <= 1'b1;
                    state <= WR_ISSUE;
                end
                WR_ISSUE: state <= WR_WAIT;
`ifdef MMCM_DRP_VERIFY_EN
                WR_WAIT: begin
                    if (DRDY) begin
                        DEN   <= 1'b1;
                        state <= VF_ISSUE;
                    end
                end
                VF_ISSUE: state <= VF_WAIT;
                VF_WAIT: begin
                    if (DRDY) begin
                        if (DO != DI) begin
                            ERR <= 1'b1;
                        end
                        if (ptr == last_ptr) begin
                            MMCM_RST <= 1'b0;
                            state    <= REL_RST;
                        end else begin
                            ptr    <= ptr_nxt;
                            DADDR  <= ent_nxt[38:32];
                            mask_q <= ent_nxt[31:16];
                            data_q <= ent_nxt[15:0];
                            DEN    <= 1'b1;
                            state  <= RD_ISSUE;
                        end
                    end
                end
`else
                WR_WAIT: begin
                    if (DRDY) begin
                        if (ptr == last_ptr) begin
                            MMCM_RST <= 1'b0;
                            state    <= REL_RST;
                        end else begin
                            ptr    <= ptr_nxt;
                            DADDR  <= ent_nxt[38:32];
                            mask_q <= ent_nxt[31:16];
                            data_q <= ent_nxt[15:0];
                            DEN    <= 1'b1;
                            state  <= RD_ISSUE;
                        end
                    end
                end
`endif
                REL_RST: begin
                    lock_cnt <= '0;
                    state    <= WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if ((lock_cnt != '0) && LOCKED) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= FINISH;
                    end else if (lock_cnt == LCW'(LOCK_TIMEOUT)) begin
                        ERR   <= 1'b1;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= FINISH;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// tb_mmcm_drp_reconfig: randomized scoreboard bench with a behavioural MMCM DRP/lock model.
// Build with MMCM_DRP_VERIFY_EN to also exercise the read-back check.
module tb_mmcm_drp_reconfig;

    localparam int NC = 3;
    localparam int RP = 4;
    localparam int LT = 100;
    localparam int CW = 2;
    localparam int AW = 4;
`ifdef MMCM_DRP_VERIFY_EN
    localparam int TPE = 3;
`else
    localparam int TPE = 2;
`endif

    logic          DCLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [CW-1:0] SEL = '0;
    logic          START = 1'b0;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic          TBL_WE = 1'b0;
    logic [AW-1:0] TBL_ADDR = '0;
    logic [38:0]   TBL_DATA = '0;
    logic [6:0]    DADDR;
    logic [15:0]   DI;
    logic [15:0]   DO = '0;
    logic          DEN;
    logic          DWE;
    logic          DRDY = 1'b0;
    logic          LOCKED = 1'b1;
    logic          MMCM_RST;

    mmcm_drp_reconfig #(
        .NUM_CFG(NC),
        .REGS_PER_CFG(RP),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .DCLK(DCLK),
        .RST_N(RST_N),
        .SEL(SEL),
        .START(START),
        .BUSY(BUSY),
        .DONE(DONE),
        .ERR(ERR),
        .TBL_WE(TBL_WE),
        .TBL_ADDR(TBL_ADDR),
        .TBL_DATA(TBL_DATA),
        .DADDR(DADDR),
        .DI(DI),
        .DO(DO),
        .DEN(DEN),
        .DWE(DWE),
        .DRDY(DRDY),
        .LOCKED(LOCKED),
        .MMCM_RST(MMCM_RST)
    );

    always #5 DCLK = ~DCLK;

    typedef struct {
        logic        we;
        logic [6:0]  a;
        logic [15:0] d;
    } txn_t;

    txn_t        exp_q[$];
    logic        done_q[$];
    logic [15:0] mem [128];
    logic [15:0] shadow [128];
    logic [38:0] tbl_m [NC*RP];

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_den = 0;
    int   n_done = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    int   done_cyc = 0;
    int   pend = 0;
    int   lat_max = 1;
    int   lock_delay = 10;
    int   lk = 0;
    logic corrupt = 1'b0;
    logic last_wr = 1'b0;
    logic [6:0] last_a = '0;
    logic [15:0] rdata = '0;
    logic prev_rst = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // DRP slave, lock model and scoreboard monitor
    always @(negedge DCLK) begin
        txn_t t;
        logic [15:0] rd;
        cyc++;
        DRDY = 1'b0;
        if (DEN) begin
            n_den++;
            check("den_while_outstanding", pend, 0);
            check("mmcm_rst_during_drp", MMCM_RST, 1);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_den: got addr %0h we %0b expected none",
                         DADDR, DWE);
            end else begin
                t = exp_q.pop_front();
                check("drp_we", DWE, t.we);
                check("drp_addr", DADDR, t.a);
                if (t.we) check("drp_di", DI, t.d);
            end
            if (DWE) begin
                mem[DADDR] = DI;
                last_wr = 1'b1;
            end else begin
                rd = mem[DADDR];
                if (corrupt && last_wr && last_a == DADDR) rd = rd ^ 16'h0001;
                rdata = rd;
                last_wr = 1'b0;
            end
            last_a = DADDR;
            pend = $urandom_range(1, lat_max);
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                DRDY = 1'b1;
                DO = rdata;
            end
        end
        if (DWE) check("dwe_needs_den", DEN, 1);
        if (DONE) begin
            n_done++;
            done_cyc = cyc;
            if (done_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got DONE expected none");
            end else begin
                check("err_at_done", ERR, done_q.pop_front());
            end
            check("busy_at_done", BUSY, 0);
        end
        if (prev_rst === 1'b1 && MMCM_RST === 1'b0) fall_cyc = cyc;
        prev_rst = MMCM_RST;
        if (MMCM_RST === 1'b1) begin
            LOCKED = 1'b0;
            lk = 0;
        end else if (!LOCKED && lock_delay > 0) begin
            lk++;
            if (lk >= lock_delay) LOCKED = 1'b1;
        end
    end

    task automatic wr_tbl(input int a, input logic [38:0] d);
        @(negedge DCLK);
        TBL_WE = 1'b1;
        TBL_ADDR = AW'(a);
        TBL_DATA = d;
        @(negedge DCLK);
        TBL_WE = 1'b0;
    endtask

    task automatic push_set(input int sel);
        int s;
        logic [38:0] e;
        logic [6:0] a;
        logic [15:0] nv;
        s = (sel >= NC) ? NC - 1 : sel;
        for (int r = 0; r < RP; r++) begin
            e = tbl_m[s*RP + r];
            a = e[38:32];
            nv = (shadow[a] & e[31:16]) | (e[15:0] & ~e[31:16]);
            shadow[a] = nv;
            exp_q.push_back('{1'b0, a, 16'h0});
            exp_q.push_back('{1'b1, a, nv});
`ifdef MMCM_DRP_VERIFY_EN
            exp_q.push_back('{1'b0, a, 16'h0});
`endif
        end
    endtask

    task automatic run(input int sel, input int dly, input logic corr,
                       input bit poke);
        logic e;
        int d0;
        int n0;
        lock_delay = dly;
        corrupt = corr;
        e = (dly == 0);
`ifdef MMCM_DRP_VERIFY_EN
        e = e | corr;
`endif
        push_set(sel);
        done_q.push_back(e);
        d0 = n_den;
        n0 = n_done;
        @(negedge DCLK);
        SEL = CW'(sel);
        START = 1'b1;
        @(negedge DCLK);
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
        check("err_cleared_by_start", ERR, 0);
        if (poke) begin
            repeat (4) @(negedge DCLK);
            SEL = CW'((sel + 1) % NC);
            START = 1'b1;
            @(negedge DCLK);
            START = 1'b0;
        end
        for (int i = 0; i < 3000 && n_done == n0; i++) @(negedge DCLK);
        check("done_seen", n_done - n0, 1);
        if (poke) begin
            repeat (30) @(negedge DCLK);
            check("ignored_start_dens", n_den - d0, RP * TPE);
            check("ignored_start_done", n_done - n0, 1);
        end
        check("exp_q_drained", exp_q.size(), 0);
        repeat (2) @(negedge DCLK);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [38:0] ent;
        int n0;
        bit got;
        for (int i = 0; i < 128; i++) begin
            mem[i] = 16'($urandom);
            shadow[i] = mem[i];
        end
        mem[8] = 16'hF3C3;
        shadow[8] = 16'hF3C3;

        RST_N = 1'b0;
        START = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge DCLK);
            check("reset_outputs",
                  {BUSY, DONE, ERR, DEN, DWE, DADDR, DI, MMCM_RST}, 0);
        end
        check("reset_no_den", n_den, 0);
        START = 1'b0;
        RST_N = 1'b1;

        for (int i = 0; i < NC*RP; i++) begin
            ent = {7'($urandom_range(9, 127)), 16'($urandom), 16'($urandom)};
            if (i == RP) ent = {7'h08, 16'h1000, 16'h0041};
            tbl_m[i] = ent;
            wr_tbl(i, ent);
        end
        wr_tbl(NC*RP, {7'h08, 16'h0000, 16'hDEAD});

        lat_max = 1;
        run(1, 10, 1'b0, 1'b0);
        check("rmw_result_0x08", mem[8], 16'h1041);

        lat_max = 3;
        for (int i = 0; i < 6; i++) begin
            run($urandom_range(0, 3), $urandom_range(1, 20), 1'b0, 1'b0);
        end

        run(0, 0, 1'b0, 1'b0);
        check("timeout_window", ((done_cyc - fall_cyc) >= LT - 2 &&
                                 (done_cyc - fall_cyc) <= LT + 6), 1);
        run(2, 5, 1'b0, 1'b0);

        run(3, 8, 1'b0, 1'b1);

`ifdef MMCM_DRP_VERIFY_EN
        run(1, 6, 1'b1, 1'b0);
        run(0, 6, 1'b0, 1'b0);
`endif

        push_set(2);
        n0 = n_done;
        @(negedge DCLK);
        SEL = CW'(2);
        START = 1'b1;
        @(negedge DCLK);
        START = 1'b0;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge DCLK);
            if (DEN && DWE) begin
                got = 1;
                break;
            end
        end
        check("abort_write_seen", got, 1);
        @(negedge DCLK);
        RST_N = 1'b0;
        @(negedge DCLK);
        check("abort_mmcm_rst", MMCM_RST, 0);
        check("abort_busy", BUSY, 0);
        check("abort_den", DEN, 0);
        RST_N = 1'b1;
        exp_q.delete();
        done_q.delete();
        repeat (20) @(negedge DCLK);
        check("abort_no_done", n_done - n0, 0);
        for (int i = 0; i < 128; i++) shadow[i] = mem[i];

        run(2, 4, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
